// File: rtl/subneg_pkg.sv
// Shared definitions for the SUBNEG program loader and the core's SRAM bus interface.
package subneg_pkg;

  // Address 8'hFF is the core's output port, not SRAM.
  localparam logic [7:0] OUT_PORT_ADDR = 8'hFF;

  typedef enum logic [3:0] {
    IDLE, WAIT_BYTE, ADR_DRV, ADR_LAT, DAT_DRV, WE_LO, WE_HI, DONE,
    RB_ADR, RB_LAT, RB_OE, RB_SMP
  } loader_state_e;

  typedef enum logic [2:0] {
    PH_RELEASE, PH_ADDR, PH_LATCH, PH_DATA, PH_WRITE, PH_READ
  } bus_phase_e;

  function automatic bus_phase_e phase_of(loader_state_e st);
    case (st)
      ADR_DRV, RB_ADR: return PH_ADDR;
      ADR_LAT, RB_LAT: return PH_LATCH;
      DAT_DRV, WE_HI:  return PH_DATA;
      WE_LO:           return PH_WRITE;
      RB_OE, RB_SMP:   return PH_READ;
      default:         return PH_RELEASE;
    endcase
  endfunction

endpackage

// File: rtl/subneg_bus_seq.sv
// Registered driver for the shared address/data bus, address latch and SRAM strobes.
// Outputs follow the phase of the state being entered, so they align with the FSM state.
module subneg_bus_seq
  import subneg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  bus_phase_e phase_nxt,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       mem_latch_clk,
  output logic       mem_oe_n,
  output logic       mem_we_n
);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_out       <= 8'h00;
      bus_oe        <= 1'b0;
      mem_latch_clk <= 1'b0;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
    end else begin
      bus_out       <= 8'h00;
      bus_oe        <= 1'b0;
      mem_latch_clk <= 1'b0;
      mem_oe_n      <= 1'b1;
      mem_we_n      <= 1'b1;
      case (phase_nxt)
        PH_ADDR: begin
          bus_out <= addr;
          bus_oe  <= 1'b1;
        end
        PH_LATCH: begin
          bus_out       <= addr;
          bus_oe        <= 1'b1;
          mem_latch_clk <= 1'b1;
        end
        PH_DATA: begin
          bus_out <= data;
          bus_oe  <= 1'b1;
        end
        PH_WRITE: begin
          bus_out  <= data;
          bus_oe   <= 1'b1;
          mem_we_n <= 1'b0;
        end
        PH_READ:  mem_oe_n <= 1'b0;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/subneg_loader.sv
// Streams program bytes into the SUBNEG SRAM, then optionally starts the core.
// Optional readback verify of every written byte: define LOADER_VERIFY_EN.
//
// state     | meaning
// IDLE      | waiting for load_start
// WAIT_BYTE | in_ready high, waiting for a byte
// ADR_DRV   | address on bus
// ADR_LAT   | address latch strobe high
// DAT_DRV   | data on bus
// WE_LO     | write strobe low
// WE_HI     | write strobe released, addr/count advance
// DONE      | session over, cpu_en raised on exit when AUTO_RUN
// RB_ADR..  | RB_ADR/RB_LAT/RB_OE/RB_SMP: readback of the byte just written
module subneg_loader
  import subneg_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'd0,
  parameter int         AUTO_RUN  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       mem_latch_clk,
  output logic       mem_oe_n,
  output logic       mem_we_n,
  output logic       cpu_en,
  output logic       busy,
  output logic [7:0] count,
  output logic       ovf,
  output logic       err
);

  loader_state_e state_q, state_d;
  logic [7:0]    addr_q, wr_addr_q, byte_q;
  logic          last_q, accept, start;

  assign in_ready = (state_q == WAIT_BYTE);
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign accept   = in_ready && in_valid;
  assign start    = (state_q == IDLE) && load_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (load_start) state_d = WAIT_BYTE;
      WAIT_BYTE: if (in_valid) state_d = (addr_q == OUT_PORT_ADDR) ? DONE : ADR_DRV;
      ADR_DRV:   state_d = ADR_LAT;
      ADR_LAT:   state_d = DAT_DRV;
      DAT_DRV:   state_d = WE_LO;
      WE_LO:     state_d = WE_HI;
`ifdef LOADER_VERIFY_EN
      WE_HI:     state_d = RB_ADR;
      RB_ADR:    state_d = RB_LAT;
      RB_LAT:    state_d = RB_OE;
      RB_OE:     state_d = RB_SMP;
      RB_SMP:    state_d = last_q ? DONE : WAIT_BYTE;
`else
      WE_HI:     state_d = last_q ? DONE : WAIT_BYTE;
`endif
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= BASE_ADDR;
      wr_addr_q <= 8'h00;
      byte_q    <= 8'h00;
      last_q    <= 1'b0;
      count     <= 8'h00;
      ovf       <= 1'b0;
      cpu_en    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q <= BASE_ADDR;
        count  <= 8'h00;
        ovf    <= 1'b0;
        cpu_en <= 1'b0;
      end
      if (accept) begin
        if (addr_q == OUT_PORT_ADDR) begin
          ovf <= 1'b1;
        end else begin
          wr_addr_q <= addr_q;
          byte_q    <= in_data;
          last_q    <= in_last;
        end
      end
      // wr_addr_q keeps the written address for readback while addr_q moves on
      if (state_q == WE_HI) begin
        addr_q <= addr_q + 8'd1;
        if (count != 8'hFF) count <= count + 8'd1;
      end
      if ((state_q == DONE) && (AUTO_RUN != 0)) cpu_en <= 1'b1;
    end
  end

`ifdef LOADER_VERIFY_EN
  always_ff @(posedge clk) begin
    if (reset || start) err <= 1'b0;
    else if ((state_q == RB_SMP) && (bus_in != byte_q)) err <= 1'b1;
  end
`else
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
  assign err = 1'b0;
`endif

  subneg_bus_seq u_bus_seq (
    .clk           (clk),
    .reset         (reset),
    .phase_nxt     (phase_of(state_d)),
    .addr          (wr_addr_q),
    .data          (byte_q),
    .bus_out       (bus_out),
    .bus_oe        (bus_oe),
    .mem_latch_clk (mem_latch_clk),
    .mem_oe_n      (mem_oe_n),
    .mem_we_n      (mem_we_n)
  );

endmodule

// File: tb/tb_subneg_loader.sv
// Bench for subneg_loader: a base-0 auto-run instance and a base-FE non-auto-run instance share one
// byte stream; each has an address-latch + SRAM model whose writes are scored against a queue.
module tb_subneg_loader;

  localparam int NDUT = 2;
`ifdef LOADER_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif
  localparam int PERIOD = VERIFY ? 10 : 6;
  localparam int TAIL   = VERIFY ? 4 : 0;

  logic       clk = 1'b0;
  logic       reset, load_start, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready_w[NDUT], bus_oe_w[NDUT], mem_latch_clk_w[NDUT], mem_oe_n_w[NDUT];
  logic       mem_we_n_w[NDUT], cpu_en_w[NDUT], busy_w[NDUT], ovf_w[NDUT], err_w[NDUT];
  logic [7:0] bus_in_w[NDUT], bus_out_w[NDUT], count_w[NDUT];

  always #5 clk = ~clk;

  subneg_loader #(.BASE_ADDR(8'h00), .AUTO_RUN(1)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_w[0]), .bus_in(bus_in_w[0]), .bus_out(bus_out_w[0]),
    .bus_oe(bus_oe_w[0]), .mem_latch_clk(mem_latch_clk_w[0]), .mem_oe_n(mem_oe_n_w[0]),
    .mem_we_n(mem_we_n_w[0]), .cpu_en(cpu_en_w[0]), .busy(busy_w[0]), .count(count_w[0]),
    .ovf(ovf_w[0]), .err(err_w[0]));

  subneg_loader #(.BASE_ADDR(8'hFE), .AUTO_RUN(0)) u_dut_hi (
    .clk(clk), .reset(reset), .load_start(load_start), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready_w[1]), .bus_in(bus_in_w[1]), .bus_out(bus_out_w[1]),
    .bus_oe(bus_oe_w[1]), .mem_latch_clk(mem_latch_clk_w[1]), .mem_oe_n(mem_oe_n_w[1]),
    .mem_we_n(mem_we_n_w[1]), .cpu_en(cpu_en_w[1]), .busy(busy_w[1]), .count(count_w[1]),
    .ovf(ovf_w[1]), .err(err_w[1]));

  int          n_vec = 0, n_err = 0, cyc = 0, acc_cyc = 0;
  logic [15:0] exp_q [NDUT][$];
  logic [7:0]  sram [NDUT][256];
  logic [7:0]  lat_q [NDUT];
  logic        prev_latch [NDUT], prev_we_n [NDUT];

  // reference model, one transaction-level record per instance
  logic [7:0]  m_addr [NDUT], m_count [NDUT];
  bit          m_ovf [NDUT], m_err [NDUT], m_active [NDUT], m_cpu [NDUT];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] base_of(int k);
    return (k == 0) ? 8'h00 : 8'hFE;
  endfunction

  // SRAM read path corrupts address 1 so the readback verify has something to catch
  for (genvar g = 0; g < NDUT; g++) begin : g_rd
    assign bus_in_w[g] = mem_oe_n_w[g] ? 8'h00
                       : (sram[g][lat_q[g]] ^ ((lat_q[g] == 8'h01) ? 8'h80 : 8'h00));
  end

  // monitor: latch captures on rising latch clock, a write commits when WE rises with the bus driven
  always @(negedge clk) begin
    logic [15:0] e;
    for (int k = 0; k < NDUT; k++) begin
      if (reset) begin
        prev_latch[k] = 1'b0;
        prev_we_n[k]  = 1'b1;
        lat_q[k]      = 8'h00;
      end else begin
        if (mem_latch_clk_w[k] && !prev_latch[k]) lat_q[k] = bus_out_w[k];
        if (!prev_we_n[k] && mem_we_n_w[k] && bus_oe_w[k]) begin
          sram[k][lat_q[k]] = bus_out_w[k];
          if (exp_q[k].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL write%0d: got %02h at addr %02h, required no write", k, bus_out_w[k], lat_q[k]);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("write%0d", k), {16'h0, lat_q[k], bus_out_w[k]}, {16'h0, e});
          end
        end
        prev_latch[k] = mem_latch_clk_w[k];
        prev_we_n[k]  = mem_we_n_w[k];
      end
    end
  end

  task automatic model_start();
    for (int k = 0; k < NDUT; k++) begin
      m_addr[k] = base_of(k); m_count[k] = 8'h00; m_ovf[k] = 0; m_err[k] = 0;
      m_active[k] = 1; m_cpu[k] = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] d, input bit last);
    for (int k = 0; k < NDUT; k++) begin
      if (!m_active[k]) continue;
      if (m_addr[k] == 8'hFF) begin
        m_ovf[k] = 1; m_active[k] = 0; m_cpu[k] = (k == 0);
      end else begin
        exp_q[k].push_back({m_addr[k], d});
        if (VERIFY && m_addr[k] == 8'h01) m_err[k] = 1;
        m_addr[k]++;
        if (m_count[k] != 8'hFF) m_count[k]++;
        if (last) begin m_active[k] = 0; m_cpu[k] = (k == 0); end
      end
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    model_start();
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit last, input bit keep_valid);
    int n;
    in_data = d; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!in_ready_w[0] && n < 64) begin @(negedge clk); n++; end
    chk("handshake_timeout", in_ready_w[0], 1'b1);
    if (in_ready_w[0]) begin model_byte(d, last); acc_cyc = cyc; end
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic end_session(input string tag);
    int n;
    n = 0;
    while ((busy_w[0] || busy_w[1]) && n < 100) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s_busy%0d", tag, k), busy_w[k], 1'b0);
      chk($sformatf("%s_count%0d", tag, k), count_w[k], m_count[k]);
      chk($sformatf("%s_ovf%0d", tag, k), ovf_w[k], m_ovf[k]);
      chk($sformatf("%s_err%0d", tag, k), err_w[k], m_err[k]);
      chk($sformatf("%s_cpu_en%0d", tag, k), cpu_en_w[k], m_cpu[k]);
      chk($sformatf("%s_bus_oe%0d", tag, k), bus_oe_w[k], 1'b0);
      chk($sformatf("%s_pending%0d", tag, k), exp_q[k].size(), 0);
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("%s_rst%0d", tag, k),
          {bus_out_w[k], count_w[k], 4'h0, bus_oe_w[k], mem_latch_clk_w[k], mem_oe_n_w[k], mem_we_n_w[k],
           1'b0, cpu_en_w[k], busy_w[k], ovf_w[k], err_w[k], in_ready_w[k], 2'b00},
          {8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by t=%0t, required finish", $time);
    $fatal(1);
  end

  initial begin
    int nb, gap, acc[6];
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    for (int k = 0; k < NDUT; k++) begin
      m_active[k] = 0; m_cpu[k] = 0;
      for (int a = 0; a < 256; a++) sram[k][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;
    @(negedge clk);
    check_reset("idle");

    // three-byte program; the FE instance writes FE then drops the second byte
    pulse_start();
    send(8'h05, 0, 0);
    send(8'h06, 0, 0);
    chk("hi_ovf_on_drop", ovf_w[1], 1'b1);
    chk("hi_done_not_busy", busy_w[1], 1'b0);
    chk("hi_count_on_drop", count_w[1], 8'h01);
    send(8'h03, 1, 0);
    repeat (4 + TAIL) @(negedge clk);
    chk("last_we_hi_busy", busy_w[0], 1'b1);
    @(negedge clk);
    chk("done_busy", busy_w[0], 1'b0);
    chk("done_cpu_en", cpu_en_w[0], 1'b0);
    @(negedge clk);
    chk("cpu_en_rise", cpu_en_w[0], 1'b1);
    end_session("prog3");
    chk("sram0_0", sram[0][0], 8'h05);
    chk("sram0_1", sram[0][1], 8'h06);
    chk("sram0_2", sram[0][2], 8'h03);
    chk("sram1_fe", sram[1][8'hFE], 8'h05);
    chk("sram1_ff", sram[1][8'hFF], 8'h00);

    // load_start mid-session must not restart the address
    pulse_start();
    send(8'($urandom), 0, 0);
    load_start = 1'b1; @(negedge clk); load_start = 1'b0;
    for (int i = 1; i < 5; i++) send(8'($urandom), i == 4, 0);
    end_session("midstart");

    // in_valid held high: one acceptance per byte period
    pulse_start();
    for (int i = 0; i < 6; i++) begin send(8'($urandom), i == 5, 1); acc[i] = acc_cyc; end
    in_valid = 1'b0;
    for (int i = 1; i < 6; i++) chk($sformatf("burst_spacing%0d", i), acc[i] - acc[i-1], PERIOD);
    end_session("burst");

    // random sessions with idle gaps
    for (int s = 0; s < 8; s++) begin
      pulse_start();
      nb = $urandom_range(1, 6);
      for (int i = 0; i < nb; i++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        send(8'($urandom), i == nb - 1, 0);
      end
      end_session($sformatf("rand%0d", s));
    end

    // reset while the second byte is in WE_LO
    pulse_start();
    send(8'($urandom), 0, 0);
    send(8'($urandom), 0, 0);
    repeat (3) @(negedge clk);
    chk("we_lo_before_reset", mem_we_n_w[0], 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check_reset("mid_write");
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) begin exp_q[k].delete(); m_active[k] = 0; end
    repeat (3) @(negedge clk);
    check_reset("after_reset");

    pulse_start();
    for (int i = 0; i < 3; i++) send(8'($urandom), i == 2, 0);
    end_session("recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
